// File: rtl/video_lock_controller.sv
// Resynchronises the HDMI timing generator to the core's native hs/vs: measures line and
// frame geometry, waits for it to settle, fires one vreset at the anchor and supervises lock.
module video_lock_controller #(
    parameter int HCNT_W          = 14,
    parameter int VCNT_W          = 10,
    parameter int STABLE_FRAMES   = 4,
    parameter int RESET_PIXEL     = 1,
    parameter int RESET_LINE_PAL  = 20,
    parameter int RESET_LINE_NTSC = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              hs,
    input  logic              vs,
    input  logic              ntscmode,
    input  logic              force_resync,
    output logic              vreset,
    output logic              locked,
    output logic [1:0]        mode,
    output logic [HCNT_W-1:0] line_len,
    output logic [VCNT_W-1:0] frame_lines,
    output logic [7:0]        resync_cnt,
    output logic [1:0]        dbg_state
);

    localparam logic [1:0] ST_SEARCH  = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_ARM     = 2'd2;
    localparam logic [1:0] ST_LOCKED  = 2'd3;

    localparam logic [HCNT_W-1:0] ANCHOR_PIXEL = HCNT_W'(RESET_PIXEL);
    localparam logic [VCNT_W-1:0] ANCHOR_PAL   = VCNT_W'(RESET_LINE_PAL);
    localparam logic [VCNT_W-1:0] ANCHOR_NTSC  = VCNT_W'(RESET_LINE_NTSC);
    localparam logic [3:0]        STABLE_LAST  = 4'(STABLE_FRAMES - 1);

    logic              r_hs_d;
    logic              r_vs_d;
    logic [HCNT_W-1:0] r_hcnt;
    logic [VCNT_W-1:0] r_vcnt;
    logic [HCNT_W-1:0] r_line_len;
    logic [VCNT_W-1:0] r_frame_lines;
    logic [1:0]        r_mode;
    logic [1:0]        r_state;
    logic [3:0]        r_stable;
    logic              r_line_bad;
    logic              r_vreset;
    logic              r_locked;
    logic [7:0]        r_resync_cnt;

    logic              w_hs_edge;
    logic              w_vs_edge;
    logic              w_line_ok;
    logic              w_frame_ok;
    logic              w_timeout;
    logic              w_line_bad_now;
    logic              w_frame_bad_now;
    logic              w_frame_good;
    logic              w_mode_chg;
    logic [VCNT_W-1:0] w_target;
    logic              w_anchor;
    logic [1:0]        w_state_nxt;
    logic [3:0]        w_stable_nxt;
    logic              w_fire;

    // vs is only meaningful at line starts, so its edge is qualified by the hs edge.
    assign w_hs_edge       = ~hs & r_hs_d;
    assign w_vs_edge       = w_hs_edge & ~vs & r_vs_d;
    assign w_line_ok       = (r_hcnt == r_line_len);
    assign w_frame_ok      = (r_vcnt == r_frame_lines);
    assign w_timeout       = &r_hcnt;
    assign w_line_bad_now  = w_hs_edge & ~w_line_ok;
    assign w_frame_bad_now = w_vs_edge & ~w_frame_ok;
    assign w_frame_good    = w_vs_edge & w_frame_ok & w_line_ok & ~r_line_bad;
    assign w_mode_chg      = (~ntscmode) != r_mode[0];
    assign w_target        = r_mode[0] ? ANCHOR_PAL : ANCHOR_NTSC;
    assign w_anchor        = (r_hcnt == ANCHOR_PIXEL) && (r_vcnt == w_target);

    always_comb begin
        w_state_nxt  = r_state;
        w_stable_nxt = r_stable;
        w_fire       = 1'b0;
        if (w_timeout) begin
            w_state_nxt  = ST_SEARCH;
            w_stable_nxt = 4'd0;
        end else begin
            case (r_state)
                ST_SEARCH: begin
                    if (w_vs_edge) begin
                        w_state_nxt  = ST_MEASURE;
                        w_stable_nxt = 4'd0;
                    end
                end
                ST_MEASURE: begin
                    if (w_vs_edge) begin
                        if (w_frame_good) begin
                            w_stable_nxt = r_stable + 4'd1;
                            if (r_stable == STABLE_LAST) begin
                                w_state_nxt = ST_ARM;
                            end
                        end else begin
                            w_stable_nxt = 4'd0;
                        end
                    end else if (w_line_bad_now) begin
                        w_stable_nxt = 4'd0;
                    end
                end
                ST_ARM: begin
                    if (w_anchor) begin
                        w_fire      = 1'b1;
                        w_state_nxt = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (w_line_bad_now || w_frame_bad_now || w_mode_chg) begin
                        w_state_nxt  = ST_MEASURE;
                        w_stable_nxt = 4'd0;
                    end else if (force_resync) begin
                        w_state_nxt = ST_ARM;
                    end
                end
                default: begin
                    w_state_nxt  = ST_SEARCH;
                    w_stable_nxt = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hs_d        <= 1'b1;
            r_vs_d        <= 1'b1;
            r_hcnt        <= '0;
            r_vcnt        <= '0;
            r_line_len    <= '0;
            r_frame_lines <= '0;
            r_mode        <= 2'd1;
            r_state       <= ST_SEARCH;
            r_stable      <= 4'd0;
            r_line_bad    <= 1'b0;
            r_vreset      <= 1'b0;
            r_locked      <= 1'b0;
            r_resync_cnt  <= 8'd0;
        end else begin
            r_hs_d   <= hs;
            r_mode   <= {1'b0, ~ntscmode};
            r_state  <= w_state_nxt;
            r_stable <= w_stable_nxt;
            r_vreset <= w_fire;
            r_locked <= (w_state_nxt == ST_LOCKED);
            if (w_fire) begin
                r_resync_cnt <= r_resync_cnt + 8'd1;
            end

            if (w_hs_edge) begin
                r_line_len <= r_hcnt;
                r_hcnt     <= '0;
                r_vs_d     <= vs;
            end else if (!w_timeout) begin
                r_hcnt <= r_hcnt + 1'b1;
            end

            if (w_vs_edge) begin
                r_frame_lines <= r_vcnt;
                r_vcnt        <= '0;
            end else if (w_hs_edge && !(&r_vcnt)) begin
                r_vcnt <= r_vcnt + 1'b1;
            end

            // Remembers any bad line since the last frame start so a frame only counts if every line matched.
            if (w_vs_edge) begin
                r_line_bad <= 1'b0;
            end else if (w_line_bad_now) begin
                r_line_bad <= 1'b1;
            end
        end
    end

    assign vreset      = r_vreset;
    assign locked      = r_locked;
    assign mode        = r_mode;
    assign line_len    = r_line_len;
    assign frame_lines = r_frame_lines;
    assign resync_cnt  = r_resync_cnt;
    assign dbg_state   = r_state;

endmodule
